// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: in-order trace queue for architectural write events.
// GRF writebacks (W stage) and DM stores (M stage) are pushed in the same
// cycle if needed, with the GRF event treated as older. A host drains the
// queue through a valid/ready port. Events that do not fit are dropped and
// counted.
module wb_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        grf_we,
  input  logic [31:0] grf_pc,
  input  logic [4:0]  grf_addr,
  input  logic [31:0] grf_data,
  input  logic        dm_we,
  input  logic [31:0] dm_pc,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_type,
  output logic [31:0] out_pc,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        overflow,
  output logic [15:0] drop_cnt,
  output logic [31:0] ev_cnt
);

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;
  logic [PTR_W+1:0] free;

  logic       gReq;
  logic       dReq;
  logic       pop;
  logic       accG;
  logic       accD;
  logic [1:0] nAcc;
  logic [1:0] nReq;
  logic [1:0] nDrop;
  logic [16:0] dropSum;

  entry_t grfEntry;
  entry_t dmEntry;
  entry_t head;

  assign gReq = grf_we & (grf_addr != 5'd0);
  assign dReq = dm_we;
  assign pop  = out_valid & out_ready;

  // A pop in the same cycle frees a slot for this cycle's pushes.
  assign free = (PTR_W+2)'(DEPTH) - {1'b0, count} + {{(PTR_W+1){1'b0}}, pop};

  // Decide which requested events fit; the older GRF event wins a single slot.
  always_comb begin
    accG = 1'b0;
    accD = 1'b0;
    if (free >= (PTR_W+2)'(2)) begin
      accG = gReq;
      accD = dReq;
    end else if (free == (PTR_W+2)'(1)) begin
      accG = gReq;
      accD = dReq & ~gReq;
    end
  end

  assign nAcc    = {1'b0, accG} + {1'b0, accD};
  assign nReq    = {1'b0, gReq} + {1'b0, dReq};
  assign nDrop   = nReq - nAcc;
  assign dropSum = {1'b0, drop_cnt} + {15'd0, nDrop};

  assign grfEntry = '{kind: 1'b0, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_data};
  assign dmEntry  = '{kind: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_data};

  // Storage is never cleared; the DM event lands just after a same-cycle GRF event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accG) mem[wrPtr] <= grfEntry;
      if (accD) mem[wrPtr + PTR_W'(accG)] <= dmEntry;
    end
  end

  // Pointer, occupancy and statistics bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
      ev_cnt   <= 32'd0;
    end else begin
      wrPtr  <= wrPtr + PTR_W'(nAcc);
      rdPtr  <= rdPtr + PTR_W'(pop);
      count  <= count + (PTR_W+1)'(nAcc) - (PTR_W+1)'(pop);
      ev_cnt <= ev_cnt + 32'(nAcc);
      if (nDrop != 2'd0) begin
        overflow <= 1'b1;
        drop_cnt <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
      end
    end
  end

  assign head      = mem[rdPtr];
  assign out_valid = (count != '0);
  assign out_type  = head.kind;
  assign out_pc    = head.pc;
  assign out_addr  = head.addr;
  assign out_data  = head.data;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed checks of wb_trace_buffer ordering, admission,
// drop accounting and reset flush.
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [31:0] dm_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_type;
  logic [31:0] out_pc;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [31:0] ev_cnt;

  int vectors = 0;
  int miscompares = 0;

  wb_trace_buffer dut (
    .clk(clk), .reset(reset),
    .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_data(grf_data),
    .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_data(dm_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
    .overflow(overflow), .drop_cnt(drop_cnt), .ev_cnt(ev_cnt)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    grf_we = 1'b0; grf_pc = '0; grf_addr = '0; grf_data = '0;
    dm_we = 1'b0; dm_pc = '0; dm_addr = '0; dm_data = '0;
  endtask

  // Drive one cycle of strobes (ready held as given), then return to idle.
  task automatic applyStimulus(input logic g, input logic [31:0] gpc, input logic [4:0] ga,
                               input logic [31:0] gd, input logic d, input logic [31:0] dpc,
                               input logic [31:0] da, input logic [31:0] dd, input logic rdy);
    grf_we = g; grf_pc = gpc; grf_addr = ga; grf_data = gd;
    dm_we = d; dm_pc = dpc; dm_addr = da; dm_data = dd;
    out_ready = rdy;
    tick();
    idle();
    out_ready = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic popOne();
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b1);
  endtask

  // Linear sequence of directed scenarios.
  initial begin
    idle();
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
    checkOutput("rst_ev", ev_cnt, 32'd0);

    $display("[TB] single GRF event");
    applyStimulus(1'b1, 32'h3000, 5'd1, 32'h1234, 1'b0, 0, 0, 0, 1'b0);
    checkOutput("t1_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_type", 32'(out_type), 32'd0);
    checkOutput("t1_pc", out_pc, 32'h3000);
    checkOutput("t1_addr", out_addr, 32'd1);
    checkOutput("t1_data", out_data, 32'h1234);
    popOne();
    checkOutput("t1_valid_after_pop", 32'(out_valid), 32'd0);
    checkOutput("t1_ev", ev_cnt, 32'd1);

    $display("[TB] dual push ordering");
    applyStimulus(1'b1, 32'h3004, 5'd2, 32'd5, 1'b1, 32'h3008, 32'h10, 32'd7, 1'b0);
    checkOutput("t2_valid", 32'(out_valid), 32'd1);
    checkOutput("t2_head_type", 32'(out_type), 32'd0);
    checkOutput("t2_head_pc", out_pc, 32'h3004);
    checkOutput("t2_head_addr", out_addr, 32'd2);
    checkOutput("t2_head_data", out_data, 32'd5);
    checkOutput("t2_ev", ev_cnt, 32'd3);
    popOne();
    checkOutput("t2_second_valid", 32'(out_valid), 32'd1);
    checkOutput("t2_second_type", 32'(out_type), 32'd1);
    checkOutput("t2_second_pc", out_pc, 32'h3008);
    checkOutput("t2_second_addr", out_addr, 32'h10);
    checkOutput("t2_second_data", out_data, 32'd7);
    popOne();
    checkOutput("t2_empty", 32'(out_valid), 32'd0);

    $display("[TB] write to zero register ignored");
    applyStimulus(1'b1, 32'h300C, 5'd0, 32'hFFFF, 1'b0, 0, 0, 0, 1'b0);
    checkOutput("t3_valid", 32'(out_valid), 32'd0);
    checkOutput("t3_ev", ev_cnt, 32'd3);
    checkOutput("t3_overflow", 32'(overflow), 32'd0);

    $display("[TB] fill to full and overflow");
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 32'h4000 + 32'(4 * i), 5'(i + 1), 32'h100 + 32'(i), 1'b0, 0, 0, 0, 1'b0);
    checkOutput("t4_ev_full", ev_cnt, 32'd19);
    checkOutput("t4_no_overflow_yet", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 32'h4040, 5'd17, 32'h999, 1'b0, 0, 0, 0, 1'b0);
    checkOutput("t4_overflow", 32'(overflow), 32'd1);
    checkOutput("t4_drop", 32'(drop_cnt), 32'd1);
    checkOutput("t4_ev", ev_cnt, 32'd19);
    checkOutput("t4_head_data", out_data, 32'h100);
    checkOutput("t4_head_pc", out_pc, 32'h4000);

    $display("[TB] full with pop and two requests");
    applyStimulus(1'b1, 32'h5000, 5'd20, 32'hAAAA, 1'b1, 32'h5004, 32'h20, 32'hBBBB, 1'b1);
    checkOutput("t5_drop", 32'(drop_cnt), 32'd2);
    checkOutput("t5_ev", ev_cnt, 32'd20);
    checkOutput("t5_head_data", out_data, 32'h101);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 32'h5008, 32'h24, 32'hCCCC, 1'b0);
    checkOutput("t5_still_full_drop", 32'(drop_cnt), 32'd3);
    for (int i = 0; i < 16; i++) begin
      checkOutput("t5_drain_valid", 32'(out_valid), 32'd1);
      checkOutput("t5_drain_data", out_data, (i < 15) ? 32'h101 + 32'(i) : 32'hAAAA);
      popOne();
    end
    checkOutput("t5_drained", 32'(out_valid), 32'd0);
    checkOutput("t5_overflow_sticky", 32'(overflow), 32'd1);

    $display("[TB] reset flush");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 32'h6000 + 32'(4 * i), 5'(i + 1), 32'(i), 1'b0, 0, 0, 0, 1'b0);
    checkOutput("t6_valid_before", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t6_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_ev", ev_cnt, 32'd0);
    checkOutput("t6_drop", 32'(drop_cnt), 32'd0);
    checkOutput("t6_overflow", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 32'h7000, 5'd3, 32'h55, 1'b0, 0, 0, 0, 1'b0);
    checkOutput("t6_push_valid", 32'(out_valid), 32'd1);
    checkOutput("t6_push_pc", out_pc, 32'h7000);
    checkOutput("t6_push_addr", out_addr, 32'd3);
    checkOutput("t6_push_data", out_data, 32'h55);
    checkOutput("t6_push_ev", ev_cnt, 32'd1);
    popOne();
    checkOutput("t6_empty", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
